multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter INSTRET_W, 32, width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, 15, maximum wait cycles in MEM before fault (used only with MEM_WAIT_EN).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  7  instruction[6:0] from the instruction register.
REQ-006 zero_flag  in  1  ALU zero result.
REQ-007 mem_ready  in  1  data-memory access complete (sampled only with MEM_WAIT_EN).
REQ-008 pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, pc_src, alu_src_a  out  1 each  datapath strobes/selects.
REQ-009 alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate.
REQ-010 alu_op  out  2  00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
REQ-011 state  out  3  current FSM state; halted  out  1  FSM in HALT; fault  out  1  sticky error flag.
REQ-012 instret  out  INSTRET_W  retired-instruction count.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with fault=1.
REQ-014 FETCH: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00; next DECODE.
REQ-015 DECODE: latch opcode into op_q; legal opcodes 0110011 R, 0010011 I-ALU, 0000011 LD, 0100011 SD, 1100011 BEQ go to EXEC; any other goes to HALT with fault=1.
REQ-016 All non-FETCH/DECODE outputs SHALL decode from state and op_q only (Moore), never from live opcode.
REQ-017 EXEC: alu_src_a=1; R: alu_src_b=00, alu_op=10 -> WB; I-ALU: alu_src_b=10, alu_op=11 -> WB; LD/SD: alu_src_b=10, alu_op=00 -> MEM; BEQ: alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero_flag -> FETCH.
REQ-018 MEM: LD asserts mem_read, SD asserts mem_write, held steady until exit; LD -> WB, SD -> FETCH.
REQ-019 WB: reg_write=1, mem_to_reg=1 for LD else 0; next FETCH.
REQ-020 Latency SHALL be BEQ 3, R/I-ALU 4, SD 4, LD 5 cycles (zero memory wait).
REQ-021 instret SHALL increment by 1 in the cycle the FSM leaves EXEC(BEQ), MEM(SD) or WB toward FETCH, and wrap from all-ones to 0.
REQ-022 HALT: all strobes 0, halted=1, instret frozen; exit only by reset.
REQ-023 Unused strobes SHALL be 0 in every state; reg_write and mem_write SHALL never be 1 simultaneously.

Reset
REQ-024 Reset SHALL force state=FETCH, op_q=0, instret=0, fault=0, wait counter=0 immediately, including mid-instruction; no strobe held over.
REQ-025 The first rising edge after reset deassertion SHALL execute FETCH.

Configuration
REQ-026 With MEM_WAIT_EN defined, MEM SHALL stay until mem_ready=1 (exit on that edge), counting wait cycles; on reaching MEM_TIMEOUT without mem_ready it SHALL enter HALT with fault=1 and no retire.
REQ-027 Without MEM_WAIT_EN, MEM SHALL last exactly one cycle, mem_ready SHALL be ignored and no wait counter SHALL exist.

Structure
REQ-028 Package cpu_ctrl_pkg SHALL hold the state encoding, the five opcode constants, and the alu_op/alu_src_b encodings.
REQ-029 One combinational sub-module, mc_out_decode, SHALL map (state, op_q, zero_flag) to all datapath outputs; the top holds FSM, op_q, wait counter and instret.

Verification
REQ-030 Reset, run opcode 0110011: states 0,1,2,4,0; reg_write=1 only in WB; instret 0 -> 1.
REQ-031 Opcode 0000011 with mem_ready=1: states 0,1,2,3,4; mem_read=1 in MEM, mem_to_reg=1 in WB; 5 cycles.
REQ-032 Opcode 1100011, zero_flag=1 then 0: pc_write=1 with pc_src=1 in EXEC first time, pc_write=0 second; 3 cycles each.
REQ-033 Opcode 1111111: DECODE -> HALT, fault=1, halted=1, instret unchanged; reset returns to FETCH with fault=0.
REQ-034 MEM_WAIT_EN, SD with mem_ready low 3 cycles: mem_write held 4 cycles then FETCH; mem_ready never high: HALT, fault=1 after 15 wait cycles.
REQ-035 Preload instret to all-ones via 2^INSTRET_W-1 retires (INSTRET_W=4 build): next retire -> 0; reset asserted in MEM -> FETCH, strobes 0 same cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU selects
// and the packed datapath control word.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] S_WB     = 3'd4;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SD  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: is_legal_op = 1'b1;
            default:                          is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: maps (state, latched opcode, zero_flag) to the datapath control word.
module mc_out_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0]  state,
    input  logic [OPCODE_W-1:0] op_q,
    input  logic                zero_flag,
    output ctrl_t               ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.ir_write  = 1'b1;
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                case (op_q)
                    OP_R: begin
                        ctrl_c.alu_src_b = SRCB_RS2;
                        ctrl_c.alu_op    = ALU_RTYPE;
                    end
                    OP_I: begin
                        ctrl_c.alu_src_b = SRCB_IMM;
                        ctrl_c.alu_op    = ALU_ITYPE;
                    end
                    OP_LD, OP_SD: begin
                        ctrl_c.alu_src_b = SRCB_IMM;
                        ctrl_c.alu_op    = ALU_ADD;
                    end
                    OP_BEQ: begin
                        ctrl_c.alu_src_b = SRCB_RS2;
                        ctrl_c.alu_op    = ALU_SUB;
                        ctrl_c.pc_src    = 1'b1;
                        ctrl_c.pc_write  = zero_flag;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_c.mem_read  = (op_q == OP_LD);
                ctrl_c.mem_write = (op_q == OP_SD);
            end
            S_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = (op_q == OP_LD);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with retired-instruction counter.
// Optional MEM_WAIT_EN: MEM waits for mem_ready with a MEM_TIMEOUT fault.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W   = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero_flag,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [STATE_W-1:0]   state,
    output logic                 halted,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    logic [STATE_W-1:0]   state_q;
    logic [STATE_W-1:0]   state_d;
    logic [OPCODE_W-1:0]  op_q;
    logic                 fault_q;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire_c;
    logic                 fault_set_c;
    ctrl_t                ctrl_c;
    ctrl_t                ctrl_gated_c;

`ifdef MEM_WAIT_EN
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              unused_mem;
    assign unused_mem = 1'b0;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_ready, 1'(MEM_TIMEOUT == 0)};
`endif

    // Next-state logic; retire and fault events are flagged on the leaving edge.
    always_comb begin
        state_d     = state_q;
        retire_c    = 1'b0;
        fault_set_c = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (is_legal_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d     = S_HALT;
                    fault_set_c = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LD, OP_SD: state_d = S_MEM;
                    OP_BEQ: begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                    default: begin
                        state_d     = S_HALT;
                        fault_set_c = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
`ifdef MEM_WAIT_EN
                if (mem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d     = S_HALT;
                    fault_set_c = 1'b1;
                end
`else
                if (op_q == OP_LD) begin
                    state_d = S_WB;
                end else begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
`endif
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d     = S_HALT;
                fault_set_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (fault_set_c) begin
                fault_q <= 1'b1;
            end
            if (retire_c) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

`ifdef MEM_WAIT_EN
    // Counts cycles spent in MEM without mem_ready; cleared whenever MEM is left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else if (state_q == S_MEM && state_d == S_MEM) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end
`endif

    mc_out_decode u_out_decode (
        .state     (state_q),
        .op_q      (op_q),
        .zero_flag (zero_flag),
        .ctrl_c    (ctrl_c)
    );

    // No strobe may reach the datapath while reset is held.
    assign ctrl_gated_c = reset ? ctrl_t'('0) : ctrl_c;

    assign pc_write   = ctrl_gated_c.pc_write;
    assign ir_write   = ctrl_gated_c.ir_write;
    assign reg_write  = ctrl_gated_c.reg_write;
    assign mem_read   = ctrl_gated_c.mem_read;
    assign mem_write  = ctrl_gated_c.mem_write;
    assign mem_to_reg = ctrl_gated_c.mem_to_reg;
    assign pc_src     = ctrl_gated_c.pc_src;
    assign alu_src_a  = ctrl_gated_c.alu_src_a;
    assign alu_src_b  = ctrl_gated_c.alu_src_b;
    assign alu_op     = ctrl_gated_c.alu_op;

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule
